// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, NOP encoding,
// redirect-enable level, FSM state encodings and a word-alignment helper.
package fetch_unit_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  // Bubble presented to if_id whenever no live instruction is available
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  // Level of jumpe_i that requests a redirect
  localparam logic JUMP_EN_LVL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // no request outstanding
    ST_WAIT = 2'b01,  // request outstanding, response will be kept
    ST_DROP = 2'b10   // request outstanding, response will be discarded
  } fetch_state_e;

  // Clear the byte-offset bits so fetches are always word aligned
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & {{(ADDR_W-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch queue holding {pc, instruction} pairs for if_id.
// Supports push, pop and flush in the same cycle; flush wins.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic [INST_W-1:0] wr_inst,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [INST_W-1:0] rd_inst,
  output logic [1:0]        count,
  output logic              empty
);

  logic [ADDR_W-1:0] pc_mem   [2];
  logic [INST_W-1:0] inst_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while count covers them
  always_ff @(posedge clk_i) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]   <= wr_pc;
      inst_mem[wr_ptr] <= wr_inst;
    end
  end

  assign rd_pc   = pc_mem[rd_ptr];
  assign rd_inst = inst_mem[rd_ptr];
  assign empty   = (count == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetch PC, single-outstanding memory request FSM
// and a two-entry queue feeding if_id. Redirects flush the queue and
// discard any in-flight response.
// Optional feature: define FETCH_MISALIGN_CHK_EN to add a registered
// misalign_o flag for redirect targets with non-zero byte offset.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                FQ_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              jumpe_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              stall_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_data_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic              misalign_o
`endif
);

  localparam logic [1:0] FQ_MAX = 2'(FQ_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] fpc_req_q;
  logic              issue;
  logic              push;
  logic              pop;
  logic              jump;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              room_idle;
  logic              room_ack;

  assign jump   = (jumpe_i == JUMP_EN_LVL);
  assign target = align_word(jump_addr_i);
  assign pop    = !fifo_empty && !stall_i && !jump;

  // From IDLE a new request fits if the queue is not full; on an ack the
  // returning word occupies a slot, so a follow-on request needs a free
  // slot after the push (or a pop freeing one in the same cycle).
  assign room_idle = (fifo_count < FQ_MAX);
  assign room_ack  = (fifo_count < (FQ_MAX - 2'd1)) || pop;

  // Fetch state and fetch PC
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      fpc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
    end
  end

  // Address of the outstanding request, captured when it is accepted
  always_ff @(posedge clk_i) begin
    if (issue) fpc_req_q <= fpc_q;
  end

  // Next-state, request and queue-push decode
  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    issue       = 1'b0;
    push        = 1'b0;
    imem_req_o  = 1'b0;
    imem_addr_o = fpc_req_q;
    case (state_q)
      ST_IDLE: begin
        imem_addr_o = fpc_q;
        if (jump) begin
          fpc_d = target;
        end else if (room_idle && rst_i) begin
          // rst_i term keeps the request low while reset is held
          imem_req_o = 1'b1;
          issue      = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        imem_req_o = 1'b1;
        if (jump) begin
          fpc_d   = target;
          state_d = imem_ack_i ? ST_IDLE : ST_DROP;
        end else if (imem_ack_i) begin
          push = 1'b1;
          if (room_ack) begin
            issue = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        imem_req_o = 1'b1;
        if (jump) fpc_d = target;
        if (imem_ack_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (issue) fpc_d = fpc_q + 32'd4;
  end

  fetch_fifo u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push),
    .pop     (pop),
    .flush   (jump),
    .wr_pc   (fpc_req_q),
    .wr_inst (imem_data_i),
    .rd_pc   (head_pc),
    .rd_inst (head_inst),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_empty ? INST_NOP : head_inst;
  assign pc_o         = fifo_empty ? '0 : head_pc;

`ifdef FETCH_MISALIGN_CHK_EN
  // One-cycle flag for a redirect target that is not word aligned
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) misalign_o <= 1'b0;
    else        misalign_o <= jump && (jump_addr_i[1:0] != 2'b00);
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Memory responses come either from a
// one-cycle-latency responder (data = ~address) or from manual driving.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk_i;
  logic        rst_i;
  logic        jumpe_i;
  logic [31:0] jump_addr_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  logic        auto_en;
  logic        auto_ack;
  logic [31:0] auto_data;
  logic        man_ack;
  logic [31:0] man_data;

  int n_checks;
  int n_errors;

  assign imem_ack_i  = auto_en ? auto_ack  : man_ack;
  assign imem_data_i = auto_en ? auto_data : man_data;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .jumpe_i      (jumpe_i),
    .jump_addr_i  (jump_addr_i),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .pc_o         (pc_o)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_o   (misalign_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Responder: acknowledges a pending request one cycle after seeing it
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      auto_ack  <= 1'b0;
      auto_data <= 32'h0;
    end else if (auto_ack) begin
      auto_ack <= 1'b0;
    end else if (imem_req_o) begin
      auto_ack  <= 1'b1;
      auto_data <= ~imem_addr_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset(input logic use_auto, input logic stall);
    @(posedge clk_i);
    #1;
    rst_i       = 1'b0;
    jumpe_i     = 1'b0;
    jump_addr_i = 32'h0;
    man_ack     = 1'b0;
    man_data    = 32'h0;
    auto_en     = use_auto;
    stall_i     = stall;
    tick();
    tick();
    rst_i = 1'b1;
    settle();
  endtask

  logic [31:0] exp_pc;
  int          seen;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_i       = 1'b0;
    jumpe_i     = 1'b0;
    jump_addr_i = 32'h0;
    stall_i     = 1'b0;
    man_ack     = 1'b0;
    man_data    = 32'h0;
    auto_en     = 1'b1;

    // Reset values before any clock edge
    #2;
    check("rst_req",   {31'b0, imem_req_o},   32'd0);
    check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("rst_inst",  inst_o, 32'h0000_0013);
    check("rst_pc",    pc_o,   32'h0);

    // Sequential fetch, no stall: pc 0,4,8 with data ~pc
    do_reset(1'b1, 1'b0);
    check("seq_req0",  {31'b0, imem_req_o}, 32'd1);
    check("seq_addr0", imem_addr_o, 32'h0);
    exp_pc = 32'h0;
    seen   = 0;
    for (int i = 0; i < 30 && seen < 3; i++) begin
      if (inst_valid_o) begin
        check("seq_pc",   pc_o,   exp_pc);
        check("seq_inst", inst_o, ~exp_pc);
        exp_pc = exp_pc + 32'd4;
        seen++;
      end
      tick();
    end
    check("seq_seen", seen, 32'd3);

    // Stall: queue fills with pc 0 and 4, requests stop, head held
    do_reset(1'b1, 1'b1);
    repeat (8) tick();
    check("stl_req",   {31'b0, imem_req_o},   32'd0);
    check("stl_valid", {31'b0, inst_valid_o}, 32'd1);
    check("stl_pc",    pc_o,   32'h0);
    check("stl_inst",  inst_o, ~32'h0);
    stall_i = 1'b0;
    settle();
    check("stl_rel_pc", pc_o, 32'h0);
    tick();
    stall_i = 1'b1;
    settle();
    check("stl_pc4",   pc_o, 32'h4);
    check("stl_req8",  {31'b0, imem_req_o}, 32'd1);
    check("stl_addr8", imem_addr_o, 32'h8);
    repeat (4) tick();
    check("stl_full_pc",  pc_o, 32'h4);
    check("stl_full_req", {31'b0, imem_req_o}, 32'd0);
    // Redirect while stalled and full: flush regardless of stall
    jumpe_i     = 1'b1;
    jump_addr_i = 32'h300;
    tick();
    jumpe_i = 1'b0;
    settle();
    check("jstl_valid", {31'b0, inst_valid_o}, 32'd0);
    check("jstl_req",   {31'b0, imem_req_o},   32'd1);
    check("jstl_addr",  imem_addr_o, 32'h300);
    tick();
    tick();
    check("jstl_pc",   pc_o,   32'h300);
    check("jstl_inst", inst_o, ~32'h300);

    // Redirect with a request outstanding: response dropped
    do_reset(1'b0, 1'b0);
    tick();
    man_ack  = 1'b1;
    man_data = ~32'h0;
    settle();
    check("drp_addr0", imem_addr_o, 32'h0);
    tick();
    man_data = ~32'h4;
    settle();
    check("drp_addr4", imem_addr_o, 32'h4);
    check("drp_pc0",   pc_o, 32'h0);
    tick();
    man_ack     = 1'b0;
    jumpe_i     = 1'b1;
    jump_addr_i = 32'h100;
    settle();
    check("drp_addr8", imem_addr_o, 32'h8);
    check("drp_pc4",   pc_o, 32'h4);
    tick();
    jumpe_i = 1'b0;
    settle();
    check("drp_flush", {31'b0, inst_valid_o}, 32'd0);
    check("drp_hold",  imem_addr_o, 32'h8);
    tick();
    man_ack  = 1'b1;
    man_data = ~32'h8;
    settle();
    check("drp_ack_valid", {31'b0, inst_valid_o}, 32'd0);
    tick();
    man_ack = 1'b0;
    settle();
    check("drp_no8",    {31'b0, inst_valid_o}, 32'd0);
    check("drp_req",    {31'b0, imem_req_o},   32'd1);
    check("drp_addr",   imem_addr_o, 32'h100);
    tick();
    man_ack  = 1'b1;
    man_data = ~32'h100;
    tick();
    man_ack = 1'b0;
    settle();
    check("drp_tgt_pc",   pc_o,   32'h100);
    check("drp_tgt_inst", inst_o, ~32'h100);

    // Redirect coinciding with ack: ack data discarded
    do_reset(1'b0, 1'b0);
    tick();
    man_ack     = 1'b1;
    man_data    = ~32'h0;
    jumpe_i     = 1'b1;
    jump_addr_i = 32'h200;
    tick();
    man_ack = 1'b0;
    jumpe_i = 1'b0;
    settle();
    check("jak_valid", {31'b0, inst_valid_o}, 32'd0);
    check("jak_req",   {31'b0, imem_req_o},   32'd1);
    check("jak_addr",  imem_addr_o, 32'h200);
    tick();
    man_ack  = 1'b1;
    man_data = ~32'h200;
    tick();
    man_ack = 1'b0;
    settle();
    check("jak_pc", pc_o, 32'h200);

    // Asynchronous reset while a request is outstanding, then stray ack
    do_reset(1'b0, 1'b0);
    tick();
    man_ack  = 1'b1;
    man_data = ~32'h0;
    tick();
    man_ack = 1'b0;
    stall_i = 1'b1;
    settle();
    check("ar_pre_valid", {31'b0, inst_valid_o}, 32'd1);
    check("ar_pre_req",   {31'b0, imem_req_o},   32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("ar_req",   {31'b0, imem_req_o},   32'd0);
    check("ar_valid", {31'b0, inst_valid_o}, 32'd0);
    check("ar_inst",  inst_o, 32'h0000_0013);
    check("ar_pc",    pc_o,   32'h0);
    man_ack  = 1'b1;
    man_data = 32'hDEAD_BEEF;
    tick();
    rst_i = 1'b1;
    settle();
    check("ar_first_req",  {31'b0, imem_req_o}, 32'd1);
    check("ar_first_addr", imem_addr_o, 32'h0);
    tick();
    man_ack = 1'b0;
    settle();
    check("ar_stray", {31'b0, inst_valid_o}, 32'd0);
    check("ar_addr",  imem_addr_o, 32'h0);
    man_ack  = 1'b1;
    man_data = ~32'h0;
    tick();
    man_ack = 1'b0;
    settle();
    check("ar_pc0",   pc_o,   32'h0);
    check("ar_inst0", inst_o, ~32'h0);

    // Misaligned redirect target is fetched word aligned
    do_reset(1'b0, 1'b0);
    jumpe_i     = 1'b1;
    jump_addr_i = 32'h102;
    settle();
    check("mis_req_blk", {31'b0, imem_req_o}, 32'd0);
    tick();
    jumpe_i = 1'b0;
    settle();
`ifdef FETCH_MISALIGN_CHK_EN
    check("mis_flag", {31'b0, misalign_o}, 32'd1);
`endif
    check("mis_req",  {31'b0, imem_req_o}, 32'd1);
    check("mis_addr", imem_addr_o, 32'h100);
    tick();
`ifdef FETCH_MISALIGN_CHK_EN
    check("mis_flag_clr", {31'b0, misalign_o}, 32'd0);
`endif
    check("mis_hold", imem_addr_o, 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
